kamus_lsu: RTL

Load/store unit sitting directly downstream of the decode/execute stage in the kamus core. It consumes decoded memory operations (`LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`, with a `mem_width_e` width and the ALU-computed address) and drives a single-outstanding request/grant/rvalid data-memory port. It returns aligned, sign- or zero-extended load data for the `MEM_RESULT` writeback path, or a completion/error flag for stores.

---
 rtl/kamus_lsu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/kamus_lsu.sv
// kamus_lsu: load/store unit with a single-outstanding req/gnt/rvalid data port.
// Decoded ops are accepted in IDLE. Misaligned or illegal ops are answered
// from ERR without touching memory. Legal ops present one request in REQ and
// wait in WAIT for the response. Each op produces a one-cycle rsp_valid_o pulse.
module kamus_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_width_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_err_i
);

  // mem_width_e encodings
  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        width_q, width_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // H needs an even address, W needs a word address, width 11 is undefined.
  function automatic logic is_illegal(input logic [1:0] width, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (width)
      WIDTH_B: bad = 1'b0;
      WIDTH_H: bad = off[0];
      WIDTH_W: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (width)
      WIDTH_B: be = 4'b0001 << off;
      WIDTH_H: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across every lane so the byte enables pick the right one.
  function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    case (width)
      WIDTH_B: d = {4{wd[7:0]}};
      WIDTH_H: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extract(input logic [1:0] width, input logic [1:0] off,
                                               input logic uns, input logic [31:0] rd);
    logic        [31:0] shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic        [31:0] res;
    shifted = rd >> {off, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (width)
      WIDTH_B: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      WIDTH_H: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = shifted;
    endcase
    return res;
  endfunction

  // Next-state, captured op fields, memory request fields and response.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    width_d     = width_q;
    uns_d       = uns_q;
    we_d        = we_q;
    dmem_we_d   = dmem_we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          off_d   = req_addr_i[1:0];
          width_d = req_width_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          if (is_illegal(req_width_i, req_addr_i[1:0])) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_REQ;
            dmem_we_d = req_we_i;
            be_d      = byte_en(req_width_i, req_addr_i[1:0]);
            addr_d    = {req_addr_i[ADDR_W-1:2], 2'b00};
            wdata_d   = lane_wdata(req_width_i, req_wdata_i);
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = dmem_err_i;
          if (!we_q && !dmem_err_i) begin
            rsp_rdata_d = load_extract(width_q, off_q, uns_q, dmem_rdata_i);
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      off_q       <= 2'b00;
      width_q     <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      dmem_we_q   <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      width_q     <= width_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      dmem_we_q   <= dmem_we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = dmem_we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_rdata_o  = rsp_rdata_q;

endmodule
